// File: rtl/param_priority_arbiter_mux.sv
// Parametrised priority / round-robin arbiter mux with valid/ready back-pressure and a registered output.
// Optional saturating transfer/stall counters are enabled by defining PRIORITY_MUX_STATS_EN.
module param_priority_arbiter_mux #(
  parameter int ATTRIBUTE_DATA_WIDTH = 135,
  parameter int DATA_GROUPS          = 4,
  parameter int GRANT_WIDTH          = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [DATA_GROUPS-1:0]                        valid_groups_i,
  input  logic [DATA_GROUPS*ATTRIBUTE_DATA_WIDTH-1:0]   data_groups_i,
  output logic [DATA_GROUPS-1:0]                        ready_groups_o,
  input  logic                                          mode_i,
  output logic                                          valid_o,
  output logic [ATTRIBUTE_DATA_WIDTH-1:0]               data_o,
  output logic [GRANT_WIDTH-1:0]                        grant_o,
  input  logic                                          ready_i
`ifdef PRIORITY_MUX_STATS_EN
  ,
  input  logic                                          stats_clear_i,
  output logic [31:0]                                   xfer_count_o,
  output logic [31:0]                                   stall_count_o
`endif
);

  localparam int W = ATTRIBUTE_DATA_WIDTH;

  generate
    if (DATA_GROUPS < 2 || DATA_GROUPS > 16) begin : g_bad_groups
      $error("param_priority_arbiter_mux: DATA_GROUPS must be in 2..16");
    end
    if (GRANT_WIDTH < $clog2(DATA_GROUPS)) begin : g_bad_grant_width
      $error("param_priority_arbiter_mux: GRANT_WIDTH too small for DATA_GROUPS");
    end
  endgenerate

  logic                   valid_q, valid_d;
  logic [W-1:0]           data_q, data_d;
  logic [GRANT_WIDTH-1:0] grant_q, grant_d;
  logic [GRANT_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  logic                   load;
  logic                   any_valid;
  logic                   xfer;
  logic [GRANT_WIDTH-1:0] fix_idx;
  logic [GRANT_WIDTH-1:0] rr_hi_idx;
  logic                   rr_hi_found;
  logic [GRANT_WIDTH-1:0] rr_lo_idx;
  logic [GRANT_WIDTH-1:0] sel_idx;
  logic [DATA_GROUPS-1:0] sel_onehot;
  logic [W-1:0]           sel_data;
  logic [W-1:0]           data_masked [DATA_GROUPS];

  // The output register only refills when empty or being drained; ready_i never reaches valid_o.
  assign load      = !valid_q || ready_i;
  assign any_valid = |valid_groups_i;

  // Fixed priority: ascending scan, last valid seen is the highest index.
  always_comb begin
    fix_idx = '0;
    for (int g = 0; g < DATA_GROUPS; g++) begin
      if (valid_groups_i[g]) begin
        fix_idx = GRANT_WIDTH'(g);
      end
    end
  end

  // Round-robin: lowest valid index above the pointer, else wrap to the lowest valid index overall.
  always_comb begin
    rr_hi_idx   = '0;
    rr_hi_found = 1'b0;
    rr_lo_idx   = '0;
    for (int g = DATA_GROUPS - 1; g >= 0; g--) begin
      if (valid_groups_i[g]) begin
        rr_lo_idx = GRANT_WIDTH'(g);
        if (GRANT_WIDTH'(g) > rr_ptr_q) begin
          rr_hi_idx   = GRANT_WIDTH'(g);
          rr_hi_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (mode_i) begin
      sel_idx = rr_hi_found ? rr_hi_idx : rr_lo_idx;
    end else begin
      sel_idx = fix_idx;
    end
    sel_onehot = any_valid ? (DATA_GROUPS'(1) << sel_idx) : '0;
  end

  assign ready_groups_o = load ? sel_onehot : '0;
  assign xfer           = load && any_valid;

  generate
    for (genvar gi = 0; gi < DATA_GROUPS; gi++) begin : g_mask
      assign data_masked[gi] = sel_onehot[gi] ? data_groups_i[gi*W +: W] : '0;
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    for (int g = 0; g < DATA_GROUPS; g++) begin
      sel_data = sel_data | data_masked[g];
    end
  end

  // Data and grant are left untouched when idle so the last word stays observable.
  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (load) begin
      valid_d = any_valid;
      if (any_valid) begin
        data_d  = sel_data;
        grant_d = sel_idx;
      end
    end
    if (xfer && mode_i) begin
      rr_ptr_d = sel_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      grant_q  <= '0;
      rr_ptr_q <= GRANT_WIDTH'(DATA_GROUPS - 1);
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign grant_o = grant_q;

`ifdef PRIORITY_MUX_STATS_EN
  logic [31:0] xfer_cnt_q, xfer_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Clear wins over a same-cycle increment; both counters saturate at all-ones.
  always_comb begin
    xfer_cnt_d  = xfer_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (stats_clear_i) begin
      xfer_cnt_d  = '0;
      stall_cnt_d = '0;
    end else begin
      if (valid_q && ready_i && (xfer_cnt_q != '1)) begin
        xfer_cnt_d = xfer_cnt_q + 32'd1;
      end
      if (valid_q && !ready_i && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      xfer_cnt_q  <= xfer_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign xfer_count_o  = xfer_cnt_q;
  assign stall_count_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_param_priority_arbiter_mux.sv
// Directed bench for param_priority_arbiter_mux: reference model plus scoreboard queue of output words.
// Counter checks are included when PRIORITY_MUX_STATS_EN is defined.
module tb_param_priority_arbiter_mux;

  localparam int W  = 135;
  localparam int N  = 4;
  localparam int GW = 4;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [GW-1:0] grant;
  } word_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    valid_groups_i;
  logic [N*W-1:0]  data_groups_i;
  logic [N-1:0]    ready_groups_o;
  logic            mode_i;
  logic            valid_o;
  logic [W-1:0]    data_o;
  logic [GW-1:0]   grant_o;
  logic            ready_i;
`ifdef PRIORITY_MUX_STATS_EN
  logic            stats_clear_i;
  logic [31:0]     xfer_count_o;
  logic [31:0]     stall_count_o;
  logic [31:0]     m_xfer;
  logic [31:0]     m_stall;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic          m_valid;
  logic [W-1:0]  m_data;
  logic [GW-1:0] m_grant;
  int            m_ptr;
  word_t         sb_q[$];
  logic [GW-1:0] rr_seen [8];

  always #5 clk = ~clk;

  param_priority_arbiter_mux #(
    .ATTRIBUTE_DATA_WIDTH(W),
    .DATA_GROUPS(N),
    .GRANT_WIDTH(GW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .valid_groups_i(valid_groups_i),
    .data_groups_i(data_groups_i),
    .ready_groups_o(ready_groups_o),
    .mode_i(mode_i),
    .valid_o(valid_o),
    .data_o(data_o),
    .grant_o(grant_o),
    .ready_i(ready_i)
`ifdef PRIORITY_MUX_STATS_EN
    ,
    .stats_clear_i(stats_clear_i),
    .xfer_count_o(xfer_count_o),
    .stall_count_o(stall_count_o)
`endif
  );

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected winner, written as searches in arbitration order; -1 when nothing is valid.
  function automatic int model_win(input logic [N-1:0] v, input logic mode, input int ptr);
    if (!mode) begin
      for (int g = N - 1; g >= 0; g--) if (v[g]) return g;
    end else begin
      for (int k = 1; k <= N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input logic [W-1:0] d2, input logic [W-1:0] d3);
    data_groups_i = {d3, d2, d1, d0};
  endtask

  // One clock: check combinational ready and consumed word before the edge, model update at the edge,
  // then registered outputs one time unit after it.
  task automatic cycle();
    int            w;
    logic          load;
    logic [N-1:0]  exp_rdy;
    word_t         wd;
    #2;
    load    = !m_valid || ready_i;
    w       = model_win(valid_groups_i, mode_i, m_ptr);
    exp_rdy = (load && w >= 0) ? (N'(1) << w) : '0;
    check("ready_groups", 160'(ready_groups_o), 160'(exp_rdy));
    if (m_valid && ready_i && !reset) begin
      check("sb_depth", 160'(sb_q.size()), 160'(1));
      if (sb_q.size() > 0) begin
        wd = sb_q.pop_front();
        check("sb_data", 160'(data_o), 160'(wd.data));
        check("sb_grant", 160'(grant_o), 160'(wd.grant));
      end
    end
    @(posedge clk);
`ifdef PRIORITY_MUX_STATS_EN
    if (reset || stats_clear_i) begin
      m_xfer  = '0;
      m_stall = '0;
    end else begin
      if (m_valid && ready_i && m_xfer != '1) m_xfer = m_xfer + 1;
      if (m_valid && !ready_i && m_stall != '1) m_stall = m_stall + 1;
    end
`endif
    if (reset) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_grant = '0;
      m_ptr   = N - 1;
      sb_q.delete();
    end else if (load) begin
      if (w >= 0) begin
        m_valid = 1'b1;
        m_data  = data_groups_i[w*W +: W];
        m_grant = GW'(w);
        sb_q.push_back('{data: m_data, grant: m_grant});
        if (mode_i) m_ptr = w;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check("valid_o", 160'(valid_o), 160'(m_valid));
    check("data_o", 160'(data_o), 160'(m_data));
    check("grant_o", 160'(grant_o), 160'(m_grant));
`ifdef PRIORITY_MUX_STATS_EN
    check("xfer_count", 160'(xfer_count_o), 160'(m_xfer));
    check("stall_count", 160'(stall_count_o), 160'(m_stall));
`endif
  endtask

  initial begin
    m_valid = 1'b0;
    m_data  = '0;
    m_grant = '0;
    m_ptr   = N - 1;
`ifdef PRIORITY_MUX_STATS_EN
    m_xfer        = '0;
    m_stall       = '0;
    stats_clear_i = 1'b0;
`endif
    reset          = 1'b1;
    valid_groups_i = '0;
    data_groups_i  = '0;
    mode_i         = 1'b0;
    ready_i        = 1'b1;
    cycle();
    cycle();
    check("reset_valid", 160'(valid_o), 160'(0));
    check("reset_grant", 160'(grant_o), 160'(0));
    reset = 1'b0;

    // Fixed priority: g2 is the highest valid group.
    set_data(W'('hA), W'('hB), W'('hC), W'(0));
    valid_groups_i = 4'b0111;
    #2;
    check("fixed_ready", 160'(ready_groups_o), 160'(4'b0100));
    cycle();
    check("fixed_data", 160'(data_o), 160'('hC));
    check("fixed_grant", 160'(grant_o), 160'(2));

    // Round-robin with everything valid: pointer still at 3 from reset.
    mode_i = 1'b1;
    set_data(W'('h11), W'('h22), W'('h33), W'('h44));
    valid_groups_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      cycle();
      rr_seen[i] = grant_o;
      $display("rr step %0d grant=%0d data=%0h", i, grant_o, data_o);
    end
    for (int i = 0; i < 8; i++) check("rr_sequence", 160'(rr_seen[i]), 160'(i % 4));

    // Back-pressure: word from g3 held for 5 stalled cycles with new requests pending.
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_data", 160'(data_o), 160'('h44));
      check("stall_grant", 160'(grant_o), 160'(3));
    end
    ready_i = 1'b1;
    cycle();
    check("unstall_grant", 160'(grant_o), 160'(0));
    check("unstall_data", 160'(data_o), 160'('h11));

    // Idle and hold: 0x55 from g1, then nothing valid.
    mode_i = 1'b0;
    set_data(W'(0), W'('h55), W'(0), W'(0));
    valid_groups_i = 4'b0010;
    cycle();
    valid_groups_i = 4'b0000;
    cycle();
    check("idle_valid", 160'(valid_o), 160'(0));
    check("idle_data", 160'(data_o), 160'('h55));
    check("idle_grant", 160'(grant_o), 160'(1));

    // Reset during a stall discards the held word and restarts round-robin at g0.
    mode_i = 1'b1;
    valid_groups_i = 4'b0001;
    cycle();
    ready_i = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_stall_valid", 160'(valid_o), 160'(0));
    check("rst_stall_grant", 160'(grant_o), 160'(0));
    ready_i = 1'b1;
    valid_groups_i = 4'b1111;
    cycle();
    check("rst_rr_grant", 160'(grant_o), 160'(0));

`ifdef PRIORITY_MUX_STATS_EN
    reset = 1'b1;
    valid_groups_i = '0;
    cycle();
    reset  = 1'b0;
    mode_i = 1'b0;
    valid_groups_i = 4'b0001;
    for (int i = 0; i < 3; i++) cycle();
    valid_groups_i = 4'b0000;
    cycle();
    valid_groups_i = 4'b0001;
    ready_i = 1'b0;
    cycle();
    valid_groups_i = 4'b0000;
    for (int i = 0; i < 4; i++) cycle();
    check("stats_xfer", 160'(xfer_count_o), 160'(3));
    check("stats_stall", 160'(stall_count_o), 160'(4));
    stats_clear_i = 1'b1;
    cycle();
    stats_clear_i = 1'b0;
    check("clear_xfer", 160'(xfer_count_o), 160'(0));
    check("clear_stall", 160'(stall_count_o), 160'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
